pipe_instr_regs: RTL and testbench

PIPE_INSTR_REGS -- requirements
Module: pipe_instr_regs

---
 rtl/pipe_instr_regs_if.sv | 35 +++
 rtl/pipe_instr_regs.sv | 140 ++++++++++++++
 tb/tb_pipe_instr_regs.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_instr_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_instr_regs_if
// Brief    : Fetch input and D/E/M/W instruction/PC outputs of pipe_instr_regs.
// Revision : 1.0
// ============================================================================
interface pipe_instr_regs_if;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [31:0] instr3;
    logic [31:0] instr4;
    logic [31:0] pc1;
    logic [31:0] pc2;
    logic [31:0] pc3;
    logic [31:0] pc4;
    logic        stall;
    logic [31:0] stall_cnt;

    modport master (
        output if_instr, if_pc,
        input  instr1, instr2, instr3, instr4,
        input  pc1, pc2, pc3, pc4,
        input  stall, stall_cnt
    );

    modport slave (
        input  if_instr, if_pc,
        output instr1, instr2, instr3, instr4,
        output pc1, pc2, pc3, pc4,
        output stall, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_instr_regs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_instr_regs
// Brief    : D/E/M/W instruction+PC registers with load-use/branch stall.
//            Define PIPE_STALL_CNT_EN to build the saturating stall counter.
// Revision : 1.0
// ============================================================================
module pipe_instr_regs (
    input  logic             clk,
    input  logic             rst_n,
    pipe_instr_regs_if.slave bus
);

    localparam logic [5:0] c_op_special = 6'b000000;
    localparam logic [5:0] c_op_j       = 6'b000010;
    localparam logic [5:0] c_op_jal     = 6'b000011;
    localparam logic [5:0] c_op_beq     = 6'b000100;
    localparam logic [5:0] c_op_ori     = 6'b001101;
    localparam logic [5:0] c_op_lui     = 6'b001111;
    localparam logic [5:0] c_op_lw      = 6'b100011;
    localparam logic [5:0] c_op_sw      = 6'b101011;
    localparam logic [5:0] c_fn_jr      = 6'b001000;
    localparam logic [5:0] c_fn_jalr    = 6'b001001;
    localparam logic [5:0] c_fn_addu    = 6'b100001;
    localparam logic [5:0] c_fn_subu    = 6'b100011;

    function automatic logic is_rtype(input logic [31:0] ins, input logic [5:0] fn);
        return (ins[31:26] == c_op_special) && (ins[5:0] == fn);
    endfunction

    function automatic logic [4:0] dest_of(input logic [31:0] ins);
        logic [4:0] d;
        d = 5'd0;
        if (is_rtype(ins, c_fn_addu) || is_rtype(ins, c_fn_subu) || is_rtype(ins, c_fn_jalr))
            d = ins[15:11];
        else if (ins[31:26] == c_op_ori || ins[31:26] == c_op_lw || ins[31:26] == c_op_lui)
            d = ins[20:16];
        else if (ins[31:26] == c_op_jal)
            d = 5'd31;
        return d;
    endfunction

    // The all-zero bubble is excluded explicitly so it never reads a register.
    function automatic logic uses_rs(input logic [31:0] ins);
        return (ins != 32'h0) && (ins[31:26] != c_op_lui) &&
               (ins[31:26] != c_op_jal) && (ins[31:26] != c_op_j);
    endfunction

    function automatic logic uses_rt(input logic [31:0] ins);
        return is_rtype(ins, c_fn_addu) || is_rtype(ins, c_fn_subu) ||
               (ins[31:26] == c_op_sw) || (ins[31:26] == c_op_beq);
    endfunction

    function automatic logic src_hit(input logic [31:0] ins, input logic [4:0] r);
        return (r != 5'd0) &&
               ((uses_rs(ins) && (r == ins[25:21])) || (uses_rt(ins) && (r == ins[20:16])));
    endfunction

    logic [31:0] instr_q [1:4];
    logic [31:0] instr_d [1:4];
    logic [31:0] pc_q    [1:4];
    logic [31:0] pc_d    [1:4];

    logic w_load_use;
    logic w_is_branch;
    logic w_branch_haz;
    logic w_stall;

    assign w_load_use   = (instr_q[2][31:26] == c_op_lw) && src_hit(instr_q[1], instr_q[2][20:16]);
    assign w_is_branch  = (instr_q[1][31:26] == c_op_beq) ||
                          is_rtype(instr_q[1], c_fn_jr) || is_rtype(instr_q[1], c_fn_jalr);
    assign w_branch_haz = w_is_branch &&
                          (src_hit(instr_q[1], dest_of(instr_q[2])) ||
                           ((instr_q[3][31:26] == c_op_lw) && src_hit(instr_q[1], instr_q[3][20:16])));
    assign w_stall      = w_load_use || w_branch_haz;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (w_stall) begin
            instr_d[2] = 32'h0;
            pc_d[2]    = 32'h0;
        end else begin
            instr_d[1] = bus.if_instr;
            pc_d[1]    = bus.if_pc;
            instr_d[2] = instr_q[1];
            pc_d[2]    = pc_q[1];
        end
        instr_d[3] = instr_q[2];
        pc_d[3]    = pc_q[2];
        instr_d[4] = instr_q[3];
        pc_d[4]    = pc_q[3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= 4; i++) begin
                instr_q[i] <= 32'h0;
                pc_q[i]    <= 32'h0;
            end
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.instr1 = instr_q[1];
    assign bus.instr2 = instr_q[2];
    assign bus.instr3 = instr_q[3];
    assign bus.instr4 = instr_q[4];
    assign bus.pc1    = pc_q[1];
    assign bus.pc2    = pc_q[2];
    assign bus.pc3    = pc_q[3];
    assign bus.pc4    = pc_q[4];
    assign bus.stall  = w_stall;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= 32'h0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_instr_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_instr_regs
// Brief    : Directed self-checking bench for pipe_instr_regs with W-stage scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pipe_instr_regs;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          cyc;
    } sb_item_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   exp_cnt;
    sb_item_t sb [$];

    pipe_instr_regs_if bus ();

    pipe_instr_regs dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef PIPE_STALL_CNT_EN
        return exp_cnt;
`else
        return 32'h0;
`endif
    endfunction

    // Any nonzero word in W must be the oldest expected instruction, on time.
    task automatic step();
        sb_item_t e;
        @(posedge clk);
        #1;
        if (bus.instr4 !== 32'h0) begin
            if (sb.size() == 0) begin
                chk("sb_extra", bus.instr4, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_instr4", bus.instr4, e.instr);
                chk("sb_pc4", bus.pc4, e.pc);
                chk("sb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    // Drive one fetch word; nstall = stall cycles it is expected to meet in D.
    task automatic feed(input logic [31:0] ins, input logic [31:0] pc, input int nstall);
        sb_item_t e;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        e.instr = ins;
        e.pc    = pc;
        e.cyc   = cyc + 4 + nstall;
        sb.push_back(e);
        step();
    endtask

    task automatic nops(input int n);
        bus.if_instr = 32'h0;
        bus.if_pc    = 32'h0;
        repeat (n) step();
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        exp_cnt = 0;
        rst_n   = 1'b0;
        bus.if_instr = 32'h0;
        bus.if_pc    = 32'h0;
        #2;
        chk("rst_instr1", bus.instr1, 32'h0);
        chk("rst_instr4", bus.instr4, 32'h0);
        chk("rst_pc4", bus.pc4, 32'h0);
        chk("rst_stall", {31'h0, bus.stall}, 32'h0);
        chk("rst_cnt", bus.stall_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight line: addu walks D..W on consecutive edges
        feed(32'h0043_0821, 32'h3000, 0);
        chk("sl_instr1", bus.instr1, 32'h0043_0821);
        chk("sl_pc1", bus.pc1, 32'h3000);
        chk("sl_stall1", {31'h0, bus.stall}, 32'h0);
        nops(1);
        chk("sl_instr2", bus.instr2, 32'h0043_0821);
        chk("sl_pc2", bus.pc2, 32'h3000);
        nops(1);
        chk("sl_instr3", bus.instr3, 32'h0043_0821);
        chk("sl_pc3", bus.pc3, 32'h3000);
        chk("sl_stall3", {31'h0, bus.stall}, 32'h0);
        nops(2);

        // Load-use: one stall, one bubble
        feed(32'h8C01_0000, 32'h3100, 0);
        chk("lu_stall0", {31'h0, bus.stall}, 32'h0);
        feed(32'h0022_1821, 32'h3104, 1);
        chk("lu_stall1", {31'h0, bus.stall}, 32'h1);
        exp_cnt = exp_cnt + 1;
        nops(1);
        chk("lu_hold", bus.instr1, 32'h0022_1821);
        chk("lu_bubble", bus.instr2, 32'h0);
        chk("lu_bubble_pc", bus.pc2, 32'h0);
        chk("lu_instr3", bus.instr3, 32'h8C01_0000);
        chk("lu_stall2", {31'h0, bus.stall}, 32'h0);
        nops(1);
        chk("lu_adv", bus.instr2, 32'h0022_1821);
        chk("lu_cnt", bus.stall_cnt, cnt_exp());
        nops(3);

        // Branch after lw: two stall cycles
        feed(32'h8C01_0000, 32'h3200, 0);
        feed(32'h1022_0003, 32'h3204, 2);
        chk("bl_stall1", {31'h0, bus.stall}, 32'h1);
        nops(1);
        chk("bl_stall2", {31'h0, bus.stall}, 32'h1);
        chk("bl_instr3", bus.instr3, 32'h8C01_0000);
        nops(1);
        chk("bl_stall3", {31'h0, bus.stall}, 32'h0);
        chk("bl_hold", bus.instr1, 32'h1022_0003);
        exp_cnt = exp_cnt + 2;
        nops(1);
        chk("bl_adv", bus.instr2, 32'h1022_0003);
        chk("bl_cnt", bus.stall_cnt, cnt_exp());
        nops(3);

        // Branch after ALU result: one stall
        feed(32'h0043_0821, 32'h3300, 0);
        feed(32'h1022_0003, 32'h3304, 1);
        chk("ba_stall1", {31'h0, bus.stall}, 32'h1);
        nops(1);
        chk("ba_stall2", {31'h0, bus.stall}, 32'h0);
        exp_cnt = exp_cnt + 1;
        nops(4);

        // jal then jr $31: one stall
        feed(32'h0C00_0100, 32'h3400, 0);
        feed(32'h03E0_0008, 32'h3404, 1);
        chk("jj_stall1", {31'h0, bus.stall}, 32'h1);
        nops(1);
        chk("jj_stall2", {31'h0, bus.stall}, 32'h0);
        exp_cnt = exp_cnt + 1;
        nops(1);
        chk("jj_cnt", bus.stall_cnt, cnt_exp());
        nops(3);

        // lw $0 never creates a dependency
        feed(32'h8C00_0000, 32'h3500, 0);
        feed(32'h0000_1821, 32'h3504, 0);
        chk("nf_stall1", {31'h0, bus.stall}, 32'h0);
        nops(1);
        chk("nf_stall2", {31'h0, bus.stall}, 32'h0);
        nops(4);
        chk("nf_cnt", bus.stall_cnt, cnt_exp());

        // Reset in the middle of a stall discards everything in flight
        feed(32'h8C01_0000, 32'h3600, 0);
        feed(32'h1022_0003, 32'h3604, 2);
        chk("mr_pre_stall", {31'h0, bus.stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_instr1", bus.instr1, 32'h0);
        chk("mr_instr2", bus.instr2, 32'h0);
        chk("mr_instr3", bus.instr3, 32'h0);
        chk("mr_pc1", bus.pc1, 32'h0);
        chk("mr_pc2", bus.pc2, 32'h0);
        chk("mr_stall", {31'h0, bus.stall}, 32'h0);
        chk("mr_cnt", bus.stall_cnt, 32'h0);
        sb.delete();
        exp_cnt = 0;
        bus.if_instr = 32'h0;
        bus.if_pc    = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release captures the fetch word
        feed(32'h0043_0821, 32'h4000, 0);
        chk("pr_instr1", bus.instr1, 32'h0043_0821);
        chk("pr_pc1", bus.pc1, 32'h4000);
        nops(5);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
